conff_unit: RTL and testbench

Parametrised successor to the branch condition flip-flop. It evaluates an extended condition-code set against a DATA_W-wide bus value when the control unit strobes con_in, and pipelines the result through PIPE_STAGES registers. The result is held as cond_met with a pending/ack handshake back to the control sequencer. The block sits between the internal bus and the control unit and feeds the PC-load decision for conditional branches.

---
 rtl/conff_pkg.sv | 40 ++++
 rtl/conff_sat_ctr.sv | 17 +
 rtl/conff_unit.sv | 85 ++++++++
 tb/tb_conff_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/conff_pkg.sv
// conff_pkg: condition codes, stage record and evaluator shared by the conff_unit slice.
package conff_pkg;
  localparam int MAX_W = 64;
  localparam logic [3:0] C2_ZERO   = 4'h0;
  localparam logic [3:0] C2_GT     = 4'h1;
  localparam logic [3:0] C2_ALWAYS = 4'h2;
  localparam logic [3:0] C2_ODD    = 4'h3;
  localparam logic [3:0] C2_NZERO  = 4'h4;
  localparam logic [3:0] C2_LE     = 4'h5;
  localparam logic [3:0] C2_NEVER  = 4'h6;
  localparam logic [3:0] C2_EVEN   = 4'h7;
  localparam logic [3:0] C2_POS    = 4'h8;
  localparam logic [3:0] C2_NEG    = 4'hC;
  typedef struct packed {
    logic valid;
    logic met;
    logic illegal;
  } stage_t;
  typedef enum logic {ST_EMPTY, ST_PENDING} pend_st_t;
  // Operand arrives zero-extended; msb selects the sign bit of the real width.
  function automatic logic [1:0] cond_eval(input logic [MAX_W-1:0] data, input logic [5:0] msb,
                                           input logic [3:0] c2);
    logic z, n;
    z = ~|data;
    n = data[msb];
    case (c2)
      C2_ZERO:   cond_eval = {1'b0, z};
      C2_NZERO:  cond_eval = {1'b0, ~z};
      C2_POS:    cond_eval = {1'b0, ~n};
      C2_NEG:    cond_eval = {1'b0, n};
      C2_GT:     cond_eval = {1'b0, ~n & ~z};
      C2_LE:     cond_eval = {1'b0, n | z};
      C2_ALWAYS: cond_eval = 2'b01;
      C2_NEVER:  cond_eval = 2'b00;
      C2_ODD:    cond_eval = {1'b0, data[0]};
      C2_EVEN:   cond_eval = {1'b0, ~data[0]};
      default:   cond_eval = 2'b10;
    endcase
  endfunction
endpackage

// File: rtl/conff_sat_ctr.sv
// conff_sat_ctr: saturating up-counter with synchronous clear taking priority over increment.
module conff_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign cnt = r_cnt;
endmodule

// File: rtl/conff_unit.sv
// conff_unit: pipelined branch-condition evaluator with pending/ack handshake.
// Define CONFF_STATS_EN to add taken/not-taken landing counters.
module conff_unit
  import conff_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] bus_out,
  input  logic [3:0]        c2,
  input  logic              con_in,
  input  logic              cond_ack,
  input  logic              flush,
  output logic              cond_met,
  output logic              cond_valid,
  output logic              cond_pending,
  output logic              overrun,
  output logic              illegal_c2
`ifdef CONFF_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       not_taken_cnt
`endif
);
  logic [1:0] w_eval;
  stage_t     w_cap, w_land;
  logic       w_land_v;
  logic       r_met, r_valid, r_ovr, r_ill;
  pend_st_t   r_st;
  assign w_eval = cond_eval(MAX_W'(bus_out), 6'(DATA_W - 1), c2);
  assign w_cap  = '{valid: con_in & ~flush, met: w_eval[0], illegal: w_eval[1]};
  // With a single stage the capture edge is also the landing edge.
  if (PIPE_STAGES == 1) begin : g_direct
    assign w_land = w_cap;
  end else begin : g_pipe
    stage_t r_stg [PIPE_STAGES-1];
    always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) for (int i = 0; i < PIPE_STAGES - 1; i++) r_stg[i] <= '0;
      else if (flush) for (int i = 0; i < PIPE_STAGES - 1; i++) r_stg[i] <= '0;
      else begin
        r_stg[0] <= w_cap;
        for (int i = 1; i < PIPE_STAGES - 1; i++) r_stg[i] <= r_stg[i-1];
      end
    assign w_land = r_stg[PIPE_STAGES-2];
  end
  assign w_land_v = w_land.valid & ~flush;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_st    <= ST_EMPTY;
      r_met   <= 1'b0;
      r_ill   <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (flush) begin
      r_st    <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= w_land_v;
      if (w_land_v) begin
        r_met <= w_land.met;
        r_ill <= w_land.illegal;
      end
      if (w_land_v && r_st == ST_PENDING && !cond_ack) r_ovr <= 1'b1;
      r_st <= w_land_v ? ST_PENDING : (cond_ack ? ST_EMPTY : r_st);
    end
  assign cond_met     = r_met;
  assign cond_valid   = r_valid;
  assign cond_pending = (r_st == ST_PENDING);
  assign overrun      = r_ovr;
  assign illegal_c2   = r_ill;
`ifdef CONFF_STATS_EN
  logic w_cnt_v;
  assign w_cnt_v = w_land_v & ~w_land.illegal;
  conff_sat_ctr #(.W(16)) u_taken (
    .clk(clk), .clr_n(clr_n), .clr(stats_clr), .inc(w_cnt_v & w_land.met), .cnt(taken_cnt)
  );
  conff_sat_ctr #(.W(16)) u_not_taken (
    .clk(clk), .clr_n(clr_n), .clr(stats_clr), .inc(w_cnt_v & ~w_land.met), .cnt(not_taken_cnt)
  );
`endif
endmodule

// File: tb/tb_conff_unit.sv
// tb_conff_unit: randomized and directed checks of conff_unit (PIPE_STAGES 1 and 3) against a timeline model.
module tb_conff_unit;
  logic        clk = 1'b0, clr_n = 1'b0;
  logic [31:0] bus_out = '0;
  logic [3:0]  c2 = '0;
  logic        con_in = 1'b0, cond_ack = 1'b0, flush = 1'b0, stats_clr = 1'b0;
  logic [1:0]  met, val, pend, ovr, ill;
  logic [15:0] tk [2];
  logic [15:0] nt [2];
  int n_cmp = 0, n_err = 0;
  int k = 8;
  bit rv [8], rm [8], ri [8];
  bit e_met [2], e_val [2], e_pend [2], e_ovr [2], e_ill [2];
  int e_tk [2], e_nt [2];
  logic prior;

  always #5 clk = ~clk;

  conff_unit #(.DATA_W(32), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .clr_n(clr_n), .bus_out(bus_out), .c2(c2), .con_in(con_in),
    .cond_ack(cond_ack), .flush(flush), .cond_met(met[0]), .cond_valid(val[0]),
    .cond_pending(pend[0]), .overrun(ovr[0]), .illegal_c2(ill[0])
`ifdef CONFF_STATS_EN
    , .stats_clr(stats_clr), .taken_cnt(tk[0]), .not_taken_cnt(nt[0])
`endif
  );
  conff_unit #(.DATA_W(32), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .clr_n(clr_n), .bus_out(bus_out), .c2(c2), .con_in(con_in),
    .cond_ack(cond_ack), .flush(flush), .cond_met(met[1]), .cond_valid(val[1]),
    .cond_pending(pend[1]), .overrun(ovr[1]), .illegal_c2(ill[1])
`ifdef CONFF_STATS_EN
    , .stats_clr(stats_clr), .taken_cnt(tk[1]), .not_taken_cnt(nt[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [1:0] ref_eval(input logic [31:0] b, input logic [3:0] c);
    bit z = (b == 0);
    bit n = $signed(b) < 0;
    case (c)
      4'h0: return {1'b0, z};
      4'h4: return {1'b0, !z};
      4'h8: return {1'b0, !n};
      4'hC: return {1'b0, n};
      4'h1: return {1'b0, !n && !z};
      4'h5: return {1'b0, n || z};
      4'h2: return 2'b01;
      4'h6: return 2'b00;
      4'h3: return {1'b0, b % 2 == 1};
      4'h7: return {1'b0, b % 2 == 0};
      default: return 2'b10;
    endcase
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("met[p%0d]", d), met[d], e_met[d]);
      chk($sformatf("valid[p%0d]", d), val[d], e_val[d]);
      chk($sformatf("pending[p%0d]", d), pend[d], e_pend[d]);
      chk($sformatf("overrun[p%0d]", d), ovr[d], e_ovr[d]);
      chk($sformatf("illegal[p%0d]", d), ill[d], e_ill[d]);
`ifdef CONFF_STATS_EN
      chk($sformatf("taken[p%0d]", d), tk[d], e_tk[d]);
      chk($sformatf("not_taken[p%0d]", d), nt[d], e_nt[d]);
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rv[i] = 0;
    for (int d = 0; d < 2; d++) begin
      e_met[d] = 0; e_val[d] = 0; e_pend[d] = 0; e_ovr[d] = 0; e_ill[d] = 0;
      e_tk[d] = 0; e_nt[d] = 0;
    end
  endtask

  task automatic drive(input logic [31:0] b, input logic [3:0] c, input logic ci,
                       input logic a, input logic f);
    bus_out = b; c2 = c; con_in = ci; cond_ack = a; flush = f;
  endtask

  // A strobe captured at edge k lands at edge k+P-1 unless a flush edge intervenes.
  task automatic step();
    bit [1:0] ev;
    int p, ix;
    bit lv;
    k++;
    ev = ref_eval(bus_out, c2);
    if (flush) for (int i = 0; i < 8; i++) rv[i] = 0;
    else begin
      rv[k%8] = con_in; rm[k%8] = ev[0]; ri[k%8] = ev[1];
    end
    for (int d = 0; d < 2; d++) begin
      p  = d ? 3 : 1;
      ix = (k - p + 1) % 8;
      lv = !flush && rv[ix];
      if (flush) begin
        e_val[d] = 0; e_pend[d] = 0; e_ovr[d] = 0;
      end else begin
        e_val[d] = lv;
        if (lv) begin
          e_met[d] = rm[ix]; e_ill[d] = ri[ix];
          if (e_pend[d] && !cond_ack) e_ovr[d] = 1;
          e_pend[d] = 1;
        end else if (cond_ack) e_pend[d] = 0;
      end
      if (stats_clr) begin
        e_tk[d] = 0; e_nt[d] = 0;
      end else if (lv && !ri[ix]) begin
        if (rm[ix] && e_tk[d] < 65535) e_tk[d]++;
        if (!rm[ix] && e_nt[d] < 65535) e_nt[d]++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [31:0] bvals [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFE};

  initial begin
    model_reset();
    #12;
    check_all();
    clr_n = 1'b1;
    // Single-stage basic handshake
    drive(0, 4'h0, 1, 0, 0); step();
    chk("t1_met", met[0], 1); chk("t1_valid", val[0], 1); chk("t1_pend", pend[0], 1);
    drive(0, 4'h0, 0, 0, 0); step();
    chk("t1_valid_pulse", val[0], 0); chk("t1_pend_hold", pend[0], 1);
    drive(0, 4'h0, 0, 1, 0); step();
    chk("t1_ack", pend[0], 0);
    // Code sweep
    for (int c = 0; c < 16; c++)
      for (int j = 0; j < 4; j++) begin
        drive(bvals[j], 4'(c), 1, 1, 0); step();
      end
    drive(0, 0, 0, 1, 0); step(); step(); step();
    drive(0, 0, 0, 0, 1); step();
    // Three back-to-back strobes through three stages
    drive(5, 4'h8, 1, 0, 0); step();
    drive(-32'sd5, 4'h8, 1, 0, 0); step();
    drive(0, 4'h8, 1, 0, 0); step();
    chk("p3_first", met[1], 1); chk("p3_ovr0", ovr[1], 0);
    drive(0, 0, 0, 0, 0); step();
    chk("p3_second", met[1], 0); chk("p3_ovr1", ovr[1], 1);
    step();
    chk("p3_third", met[1], 1);
    // Landing with same-cycle ack
    drive(0, 0, 0, 0, 1); step();
    drive(0, 4'h0, 1, 0, 0); step();
    drive(0, 4'h4, 1, 1, 0); step();
    chk("land_ack_pend", pend[0], 1); chk("land_ack_ovr", ovr[0], 0);
    drive(0, 0, 0, 1, 0); step(); step(); step();
    // Flush with a result in flight and a same-cycle strobe
    prior = met[1];
    drive(0, 4'h4, 1, 0, 0); step();
    drive(0, 4'h0, 1, 0, 1); step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_no_valid", val[1], 0);
    end
    chk("flush_pend", pend[1], 0); chk("flush_met_hold", met[1], prior);
    // Asynchronous reset mid-pipeline
    drive(1, 4'h3, 1, 0, 0); step(); step();
    #3 clr_n = 1'b0;
    #1 model_reset(); check_all();
    #2 clr_n = 1'b1;
    drive(0, 0, 0, 0, 0); step(); step(); step();
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = 1;
        2: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      drive(b, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      stats_clr = $urandom_range(0, 49) == 0;
      step();
    end
    stats_clr = 1'b0;
`ifdef CONFF_STATS_EN
    drive(0, 0, 0, 0, 1); stats_clr = 1'b1; step();
    stats_clr = 1'b0;
    drive(0, 4'h2, 1, 1, 0);
    for (int i = 0; i < 70000; i++) step();
    chk("taken_sat", tk[0], 16'hFFFF);
    drive(0, 0, 0, 0, 0); stats_clr = 1'b1; step();
    chk("taken_clr", tk[0], 0);
    stats_clr = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
